// File: rtl/lane_join_derotate.sv
// Joins NUM_LANES independently buffered input lanes into one output beat.
// The beat can optionally be de-rotated by a per-beat offset that advances on every pop.
module lane_join_derotate #(
   parameter int NUM_LANES  = 3,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
   input  logic [NUM_LANES-1:0]            data_in_valid_arr,
   output logic [NUM_LANES-1:0]            data_in_ready_arr,
   input  logic                            derotate_en,
   output logic [NUM_LANES*DATA_WIDTH-1:0] data_out,
   output logic                            data_out_valid,
   input  logic                            data_out_ready,
   output logic [$clog2(NUM_LANES)-1:0]    rot_offset
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int ROT_W = $clog2(NUM_LANES);

   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [ROT_W-1:0] ROT_ZERO = {ROT_W{1'b0}};
   localparam logic [ROT_W-1:0] ROT_ONE  = ROT_W'(1);
   localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(NUM_LANES - 1);

   logic [DATA_WIDTH-1:0] head_s [NUM_LANES];
   logic [NUM_LANES-1:0]  nonempty_s;
   logic                  valid_s;
   logic                  pop_s;
   logic [ROT_W-1:0]      rot_r;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? PTR_ZERO : p + PTR_ONE;
   endfunction

   // Source lane feeding output lane j once the beat has been rotated left by rot.
   function automatic logic [ROT_W-1:0] src_lane(input int j, input logic [ROT_W-1:0] rot);
      int s;
      s = (j + NUM_LANES - int'(rot)) % NUM_LANES;
      return ROT_W'(s);
   endfunction

   // Join decision uses registered counts only; reset masks it off immediately.
   always_comb begin
      valid_s = rst & (&nonempty_s);
      pop_s   = valid_s & data_out_ready;
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
      logic [PTR_W-1:0]      rd_ptr_r;
      logic [PTR_W-1:0]      wr_ptr_r;
      logic [CNT_W-1:0]      cnt_r;
      logic                  ready_s;
      logic                  push_s;

      // Ready depends only on the stored count and reset, never on downstream ready.
      always_comb begin
         ready_s = rst & (cnt_r < CNT_FULL);
         push_s  = data_in_valid_arr[i] & ready_s;
      end

      assign data_in_ready_arr[i] = ready_s;
      assign nonempty_s[i]        = (cnt_r != CNT_ZERO);
      assign head_s[i]            = mem_r[rd_ptr_r];

      // Lane storage is not reset; the count gates every read so stale words never leave.
      always_ff @(posedge clk) begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      // Pointer and occupancy update; a push and pop together keep the count steady.
      always_ff @(posedge clk) begin
         if (!rst) begin
            cnt_r    <= CNT_ZERO;
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
         end else begin
            if (push_s) begin
               wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
               rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
               2'b10:   cnt_r <= cnt_r + CNT_ONE;
               2'b01:   cnt_r <= cnt_r - CNT_ONE;
               default: cnt_r <= cnt_r;
            endcase
         end
      end
   end

   // Rotation offset advances once per joined beat, independent of derotate_en.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rot_r <= ROT_ZERO;
      end else if (pop_s) begin
         rot_r <= (rot_r == ROT_LAST) ? ROT_ZERO : rot_r + ROT_ONE;
      end else begin
         rot_r <= rot_r;
      end
   end

   for (genvar j = 0; j < NUM_LANES; j++) begin : g_out
      logic [ROT_W-1:0]      src_s;
      logic [DATA_WIDTH-1:0] sel_s;

      // Output lane select; zero whenever no complete beat is present.
      always_comb begin
         src_s = src_lane(j, rot_r);
         if (!valid_s) begin
            sel_s = {DATA_WIDTH{1'b0}};
         end else if (derotate_en) begin
            sel_s = head_s[src_s];
         end else begin
            sel_s = head_s[j];
         end
      end

      assign data_out[j*DATA_WIDTH +: DATA_WIDTH] = sel_s;
   end

   assign data_out_valid = valid_s;
   assign rot_offset     = rot_r;

endmodule

// File: tb/tb_lane_join_derotate.sv
// Directed scoreboard bench for lane_join_derotate with default parameters
// (3 lanes x 8 bits, 2-entry lane buffers).
module tb_lane_join_derotate;

   localparam int N  = 3;
   localparam int W  = 8;
   localparam int RW = $clog2(N);

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] data_in;
   logic [N-1:0]   data_in_valid_arr;
   logic [N-1:0]   data_in_ready_arr;
   logic           derotate_en;
   logic [N*W-1:0] data_out;
   logic           data_out_valid;
   logic           data_out_ready;
   logic [RW-1:0]  rot_offset;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fail_cnt  = 0;
   int exp_rot   = 0;
   logic [N*W-1:0] exp_q [$];

   lane_join_derotate #(.NUM_LANES(N), .DATA_WIDTH(W), .FIFO_DEPTH(2)) dut (
      .clk               (clk),
      .rst               (rst),
      .data_in           (data_in),
      .data_in_valid_arr (data_in_valid_arr),
      .data_in_ready_arr (data_in_ready_arr),
      .derotate_en       (derotate_en),
      .data_out          (data_out),
      .data_out_valid    (data_out_valid),
      .data_out_ready    (data_out_ready),
      .rot_offset        (rot_offset)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pops n beats with downstream ready held high, comparing against the scoreboard.
   task automatic drain(input int n, input string tag);
      logic [N*W-1:0] e;
      data_out_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         chk({tag, "_valid"}, 32'(data_out_valid), 32'd1);
         if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, 32'(data_out), 32'(e));
         end
         chk({tag, "_rot"}, 32'(rot_offset), 32'(exp_rot));
         tick();
         exp_rot = (exp_rot + 1) % N;
      end
      data_out_ready = 1'b0;
      chk({tag, "_empty_after"}, 32'(data_out_valid), 32'd0);
   endtask

   initial begin
      // Reset held for 3 cycles with all lanes offering data.
      rst               = 1'b0;
      data_in_valid_arr = 3'b111;
      data_in           = 24'hAABBCC;
      derotate_en       = 1'b0;
      data_out_ready    = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_ready", 32'(data_in_ready_arr), 32'd0);
         chk("rst_valid", 32'(data_out_valid), 32'd0);
         chk("rst_rot", 32'(rot_offset), 32'd0);
         chk("rst_dout", 32'(data_out), 32'd0);
      end
      rst               = 1'b1;
      data_in_valid_arr = 3'b000;
      #1;
      chk("rel_ready", 32'(data_in_ready_arr), 32'd7);
      chk("rel_valid", 32'(data_out_valid), 32'd0);

      // Skewed arrival: lane0 at cycle 0, lane1 at cycle 2, lane2 at cycle 5.
      data_in = 24'h332211;
      for (int c = 0; c < 6; c++) begin
         data_in_valid_arr = (c == 0) ? 3'b001 : (c == 2) ? 3'b010 : (c == 5) ? 3'b100 : 3'b000;
         tick();
         if (c < 5) chk("skew_early_valid", 32'(data_out_valid), 32'd0);
      end
      data_in_valid_arr = 3'b000;
      exp_q.push_back(24'h332211);
      drain(1, "skew");

      // Back-pressure: each lane takes exactly two words, then stalls.
      data_out_ready    = 1'b0;
      data_in_valid_arr = 3'b111;
      for (int k = 0; k < 4; k++) begin
         data_in = {8'h30 + 8'(k), 8'h20 + 8'(k), 8'h10 + 8'(k)};
         tick();
         chk("bp_ready", 32'(data_in_ready_arr), (k == 0) ? 32'd7 : 32'd0);
      end
      data_in_valid_arr = 3'b000;
      exp_q.push_back(24'h302010);
      exp_q.push_back(24'h312111);
      drain(2, "bp");

      // One plain beat to bring the offset to 1.
      data_in_valid_arr = 3'b111;
      data_in           = 24'h776655;
      exp_q.push_back(24'h776655);
      tick();
      data_in_valid_arr = 3'b000;
      drain(1, "pre_rot");

      // De-rotation at offset 1: lanes (0,1,2) pushed as (B1,B2,B0) come out as (B0,B1,B2).
      derotate_en       = 1'b1;
      data_in_valid_arr = 3'b111;
      data_in           = 24'hB0B2B1;
      exp_q.push_back(24'hB2B1B0);
      tick();
      data_in_valid_arr = 3'b000;
      derotate_en       = 1'b0;
      #1;
      chk("derot_off_raw", 32'(data_out), 32'hB0B2B1);
      derotate_en = 1'b1;
      #1;
      drain(1, "derot1");

      // De-rotation at offset 2: out lane j takes input lane (j+1) mod 3.
      data_in_valid_arr = 3'b111;
      data_in           = 24'hC2C1C0;
      exp_q.push_back(24'hC0C2C1);
      tick();
      data_in_valid_arr = 3'b000;
      drain(1, "derot2");
      derotate_en = 1'b0;

      // Full-rate streaming: four consecutive pops, offset 0,1,2,0.
      data_out_ready    = 1'b1;
      data_in_valid_arr = 3'b111;
      for (int k = 0; k < 4; k++) begin
         data_in = 24'h524130 + 24'h010101 * 24'(k);
         exp_q.push_back(data_in);
         tick();
         chk("stream_valid", 32'(data_out_valid), 32'd1);
         chk("stream_data", 32'(data_out), 32'(exp_q.pop_front()));
         chk("stream_rot", 32'(rot_offset), 32'(exp_rot));
         exp_rot = (exp_rot + 1) % N;
      end
      data_in_valid_arr = 3'b000;
      tick();
      data_out_ready = 1'b0;
      chk("stream_end_valid", 32'(data_out_valid), 32'd0);
      chk("stream_end_rot", 32'(rot_offset), 32'(exp_rot));

      // Partial fill of lane0, then a one-cycle reset discards it.
      data_in_valid_arr = 3'b001;
      data_in           = 24'h000099;
      tick();
      tick();
      chk("fill0_ready", 32'(data_in_ready_arr), 32'd6);
      chk("fill0_valid", 32'(data_out_valid), 32'd0);
      data_in_valid_arr = 3'b000;
      rst               = 1'b0;
      tick();
      chk("mid_rst_ready", 32'(data_in_ready_arr), 32'd0);
      chk("mid_rst_rot", 32'(rot_offset), 32'd0);
      rst     = 1'b1;
      exp_rot = 0;
      data_in_valid_arr = 3'b111;
      data_in           = 24'h030201;
      exp_q.push_back(24'h030201);
      tick();
      data_in_valid_arr = 3'b000;
      drain(1, "post_rst");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
